// File: rtl/wash_run.sv
// Wash-execution stage: charges the programme cost on confirm, then sequences
// WASH -> RINSE -> SPIN on a 1-second tick with pause/resume support.
module wash_run #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned W0 = 10, parameter int unsigned R0 = 5,  parameter int unsigned S0 = 5,  parameter int unsigned C0 = 5,
  parameter int unsigned W1 = 20, parameter int unsigned R1 = 10, parameter int unsigned S1 = 10, parameter int unsigned C1 = 10,
  parameter int unsigned W2 = 30, parameter int unsigned R2 = 15, parameter int unsigned S2 = 15, parameter int unsigned C2 = 15,
  parameter int unsigned W3 = 0,  parameter int unsigned R3 = 0,  parameter int unsigned S3 = 10, parameter int unsigned C3 = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       pre_ok,
  input  logic [9:0] bal_in,
  input  logic [1:0] mode,
  output logic [9:0] bal_out,
  output logic [2:0] state,
  output logic [6:0] sec_left,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] motor,
  output logic       valve
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WASH  = 3'd1,
    RINSE = 3'd2,
    SPIN  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t        cur, nxt, ret, ret_n;
  logic          s1, s2, s2_d, sp;
  logic [CW-1:0] tcnt, tcnt_n;
  logic [6:0]    ph, ph_n, r_len, r_len_n, s_len, s_len_n, sec, sec_n;
  logic [9:0]    bal, bal_n;
  logic          done_q, done_n;
  logic          run, tick;
  logic [6:0]    w_sel, r_sel, s_sel;
  logic [9:0]    c_sel;

  assign sp   = s2 & ~s2_d;
  assign run  = (cur == WASH) || (cur == RINSE) || (cur == SPIN);
  assign tick = run && (tcnt == TMAX);

  always_comb begin
    case (mode)
      2'd0:    begin w_sel = 7'(W0); r_sel = 7'(R0); s_sel = 7'(S0); c_sel = 10'(C0); end
      2'd1:    begin w_sel = 7'(W1); r_sel = 7'(R1); s_sel = 7'(S1); c_sel = 10'(C1); end
      2'd2:    begin w_sel = 7'(W2); r_sel = 7'(R2); s_sel = 7'(S2); c_sel = 10'(C2); end
      default: begin w_sel = 7'(W3); r_sel = 7'(R3); s_sel = 7'(S3); c_sel = 10'(C3); end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur    <= IDLE;
      ret    <= IDLE;
      s1     <= 1'b0;
      s2     <= 1'b0;
      s2_d   <= 1'b0;
      tcnt   <= '0;
      ph     <= '0;
      r_len  <= '0;
      s_len  <= '0;
      sec    <= '0;
      bal    <= '0;
      done_q <= 1'b0;
    end else begin
      cur    <= nxt;
      ret    <= ret_n;
      s1     <= start_btn;
      s2     <= s1;
      s2_d   <= s2;
      tcnt   <= tcnt_n;
      ph     <= ph_n;
      r_len  <= r_len_n;
      s_len  <= s_len_n;
      sec    <= sec_n;
      bal    <= bal_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    nxt     = cur;
    ret_n   = ret;
    tcnt_n  = tcnt;
    ph_n    = ph;
    r_len_n = r_len;
    s_len_n = s_len;
    sec_n   = sec;
    bal_n   = bal;
    done_n  = 1'b0;
    if (run) tcnt_n = tick ? '0 : tcnt + 1'b1;
    case (cur)
      IDLE: begin
        tcnt_n = '0;
        bal_n  = bal_in;
        if (sp && pre_ok) begin
          r_len_n = r_sel;
          s_len_n = s_sel;
          if (bal_in >= c_sel) begin
            bal_n = bal_in - c_sel;
            sec_n = w_sel + r_sel + s_sel;
            if (w_sel != '0)      begin nxt = WASH;  ph_n = w_sel; end
            else if (r_sel != '0) begin nxt = RINSE; ph_n = r_sel; end
            else if (s_sel != '0) begin nxt = SPIN;  ph_n = s_sel; end
            else begin nxt = DONE; ph_n = '0; sec_n = '0; done_n = 1'b1; end
          end else begin
            nxt = ERR;
          end
        end
      end
      WASH, RINSE, SPIN: begin
        if (tick) begin
          sec_n = sec - 7'd1;
          if (ph == 7'd1) begin
            if (cur == WASH && r_len != '0)      begin nxt = RINSE; ph_n = r_len; end
            else if (cur != SPIN && s_len != '0) begin nxt = SPIN;  ph_n = s_len; end
            else begin nxt = DONE; ph_n = '0; sec_n = '0; done_n = 1'b1; end
          end else begin
            ph_n = ph - 7'd1;
          end
        end
        // A press landing on a phase-ending tick is dropped; the advance wins.
        if (sp && !(tick && ph == 7'd1)) begin
          nxt   = PAUSE;
          ret_n = cur;
        end
      end
      PAUSE: if (sp) nxt = ret;
      DONE, ERR: begin
        if (sp) begin
          nxt    = IDLE;
          tcnt_n = '0;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign state    = cur;
  assign bal_out  = bal;
  assign sec_left = sec;
  assign done     = done_q;
  assign busy     = run || (cur == PAUSE);
  assign err      = (cur == ERR);
  assign valve    = (cur == WASH) || (cur == RINSE);

  always_comb begin
    case (cur)
      WASH:    motor = 2'b01;
      RINSE:   motor = 2'b10;
      SPIN:    motor = 2'b11;
      default: motor = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_wash_run.sv
// Directed self-checking bench for wash_run with a 4-cycle tick.
module tb_wash_run;

  logic       clk = 1'b0;
  logic       rst_n, start_btn, pre_ok;
  logic [9:0] bal_in;
  logic [1:0] mode;
  logic [9:0] bal_out;
  logic [2:0] state;
  logic [6:0] sec_left;
  logic       busy, done, err, valve;
  logic [1:0] motor;

  int compared = 0;
  int mism     = 0;

  wash_run #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .pre_ok(pre_ok),
    .bal_in(bal_in), .mode(mode), .bal_out(bal_out), .state(state),
    .sec_left(sec_left), .busy(busy), .done(done), .err(err),
    .motor(motor), .valve(valve)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Button held for exactly the three edges that reach a state change.
  task automatic press();
    start_btn = 1'b1;
    step(3);
    start_btn = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_btn = 1'b0; pre_ok = 1'b0; bal_in = '0; mode = '0;
    step(2);
    chk("rst_state", state, 0);
    chk("rst_bal", bal_out, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(2);

    // Normal programme: cost 10, 20/10/10 seconds
    bal_in = 10'd100; mode = 2'd1; pre_ok = 1'b1;
    press();
    chk("n_state", state, 1);
    chk("n_bal", bal_out, 90);
    chk("n_sec", sec_left, 40);
    chk("n_motor", motor, 1);
    chk("n_valve", valve, 1);
    chk("n_busy", busy, 1);
    step(79);
    chk("n_wash_end_state", state, 1);
    chk("n_wash_end_sec", sec_left, 21);
    step(1);
    chk("n_rinse_state", state, 2);
    chk("n_rinse_sec", sec_left, 20);
    chk("n_rinse_motor", motor, 2);
    step(79);
    chk("n_spin_state", state, 3);
    chk("n_spin_sec", sec_left, 1);
    chk("n_spin_valve", valve, 0);
    step(1);
    chk("n_done_state", state, 5);
    chk("n_done_pulse", done, 1);
    chk("n_done_sec", sec_left, 0);
    chk("n_done_bal", bal_out, 90);
    chk("n_done_busy", busy, 0);
    step(1);
    chk("n_done_once", done, 0);
    chk("n_done_hold", state, 5);
    bal_in = 10'd12; mode = 2'd2;
    press();
    chk("n_back_idle", state, 0);
    step(1);
    chk("idle_track", bal_out, 12);

    // Insufficient balance for heavy programme
    step(2);
    press();
    chk("e_state", state, 6);
    chk("e_err", err, 1);
    chk("e_bal", bal_out, 12);
    chk("e_busy", busy, 0);
    step(3);
    press();
    chk("e_clear_state", state, 0);
    chk("e_clear_err", err, 0);

    // Spin-only programme with exact balance, then reset mid-SPIN
    step(2);
    bal_in = 10'd3; mode = 2'd3;
    step(2);
    press();
    chk("s_state", state, 3);
    chk("s_bal", bal_out, 0);
    chk("s_sec", sec_left, 10);
    chk("s_valve", valve, 0);
    chk("s_motor", motor, 3);
    step(12);
    chk("s_sec7", sec_left, 7);
    rst_n = 1'b0;
    step(1);
    chk("r_state", state, 0);
    chk("r_sec", sec_left, 0);
    chk("r_motor", motor, 0);
    chk("r_bal", bal_out, 0);
    rst_n = 1'b1;
    step(3);

    // Pause/resume in quick programme, then a press on a phase-ending tick
    bal_in = 10'd100; mode = 2'd0;
    step(1);
    press();
    chk("p_state", state, 1);
    chk("p_bal", bal_out, 95);
    chk("p_sec", sec_left, 20);
    step(20);
    chk("p_sec15", sec_left, 15);
    press();
    chk("p_paused", state, 4);
    chk("p_motor", motor, 0);
    chk("p_valve", valve, 0);
    chk("p_busy", busy, 1);
    chk("p_sec_at", sec_left, 15);
    step(100);
    chk("p_held_sec", sec_left, 15);
    chk("p_held_state", state, 4);
    press();
    chk("p_resume", state, 1);
    chk("p_resume_sec", sec_left, 15);
    step(1);
    chk("p_count_on", sec_left, 14);
    step(13);
    press();
    chk("f_tick_wins", state, 2);
    chk("f_sec", sec_left, 10);
    step(5);
    chk("f_no_pause", state, 2);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(3);

    // No start without pre_ok, and a held button gives no new edge
    pre_ok = 1'b0;
    start_btn = 1'b1;
    step(3);
    chk("q_no_preok", state, 0);
    pre_ok = 1'b1;
    step(50);
    chk("q_hold", state, 0);
    start_btn = 1'b0;
    step(3);
    press();
    chk("q_start", state, 1);
    chk("q_sec", sec_left, 20);
    chk("q_bal", bal_out, 95);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
